// File: rtl/rom_loader.sv
// rom_loader
//   Boot-time sequencer that fills rom_master with an iNES image delivered as
//   a byte stream (host or UART). It checks the 16-byte header (16k PRG /
//   8k CHR NROM only), drives the rom_master programming path and holds the
//   CPU core in reset until a complete, valid image has been written.
//
// Ports
//   cpu_clk    in   1   sole clock, rising edge
//   rst        in   1   asynchronous, active-low reset
//   start      in   1   one-cycle pulse: begin or restart a load
//   in_valid   in   1   stream byte valid
//   in_data    in   8   stream byte
//   in_ready   out  1   loader accepts a byte (transfer = in_valid && in_ready)
//   prog       out  1   rom_master write mode
//   prog_ab    out  16  rom_master byte address (0 .. 'h600F)
//   prog_di    out  8   rom_master write data
//   prog_we    out  1   write strobe, one cycle per byte
//   cpu_rst_n  out  1   CPU reset hold, low until a load completes
//   done       out  1   image loaded and valid
//   err        out  1   load aborted
//   err_code   out  2   0 bad magic, 1 bad PRG/CHR count, 2 mapper != 0, 3 timeout
//
// Build option
//   LOADER_TIMEOUT_EN  when defined, a gap counter aborts the load (err_code 3)
//                      after TIMEOUT_CYC consecutive cycles without a transfer
//                      while a load is in progress. Undefined: waits forever.
//
// State | meaning
//   IDLE | after reset, waiting for start
//   HDR  | accepting and checking header bytes 0..15
//   PRG  | accepting PRG bytes
//   CHR  | accepting CHR bytes
//   FIN  | one cycle while the final write strobe completes
//   DONE | image valid, CPU released
//   ERR  | load aborted, stream no longer consumed

module rom_loader #(
    parameter int HDR_BYTES   = 16,
    parameter int PRG_BYTES   = 'h4000,
    parameter int CHR_BYTES   = 'h2000,
    parameter int TIMEOUT_CYC = 'hFFFFF
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        prog,
    output logic [15:0] prog_ab,
    output logic [7:0]  prog_di,
    output logic        prog_we,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_PRG  = 3'd2;
    localparam logic [2:0] S_CHR  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [15:0] HDR_END = 16'(HDR_BYTES - 1);
    localparam logic [15:0] PRG_END = 16'(HDR_BYTES + PRG_BYTES - 1);
    localparam logic [15:0] CHR_END = 16'(HDR_BYTES + PRG_BYTES + CHR_BYTES - 1);

    logic [2:0]  state;
    logic [15:0] idx;
    logic        active;
    logic        xfer;
    logic        hdr_bad;
    logic [1:0]  hdr_code;
    logic        timeout_hit;

    assign active    = (state == S_HDR) || (state == S_PRG) || (state == S_CHR);
    assign xfer      = in_valid && active;
    assign in_ready  = active;
    assign prog      = active || (state == S_FIN);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign cpu_rst_n = (state == S_DONE);

    // Header byte check for the byte currently on the stream; only acted on
    // when that byte actually transfers.
    always_comb begin
        hdr_bad  = 1'b0;
        hdr_code = 2'd0;
        if (state == S_HDR) begin
            case (idx)
                16'd0: hdr_bad = (in_data != 8'h4E);
                16'd1: hdr_bad = (in_data != 8'h45);
                16'd2: hdr_bad = (in_data != 8'h53);
                16'd3: hdr_bad = (in_data != 8'h1A);
                16'd4, 16'd5: begin
                    hdr_bad  = (in_data != 8'h01);
                    hdr_code = 2'd1;
                end
                16'd6, 16'd7: begin
                    hdr_bad  = (in_data[7:4] != 4'h0);
                    hdr_code = 2'd2;
                end
                default: hdr_bad = 1'b0;
            endcase
        end
    end

`ifdef LOADER_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYC + 1);

    logic [GW-1:0] gap;

    // Held at zero outside a load, so entry to HDR always starts from zero.
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            gap <= '0;
        end else if (!active || xfer) begin
            gap <= '0;
        end else begin
            gap <= gap + 1'b1;
        end
    end

    // The TIMEOUT_CYC-th idle cycle in a row is the one that aborts.
    assign timeout_hit = active && !xfer && (gap == GW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            prog_ab  <= '0;
            prog_di  <= '0;
            prog_we  <= 1'b0;
            err_code <= 2'd0;
        end else begin
            prog_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_HDR;
                        idx   <= '0;
                    end
                end
                S_HDR, S_PRG, S_CHR: begin
                    if (xfer) begin
                        // A failing header byte is still written before aborting.
                        prog_ab <= idx;
                        prog_di <= in_data;
                        prog_we <= 1'b1;
                        idx     <= idx + 16'd1;
                        if (hdr_bad) begin
                            state    <= S_ERR;
                            err_code <= hdr_code;
                        end else if (state == S_HDR && idx == HDR_END) begin
                            state <= S_PRG;
                        end else if (state == S_PRG && idx == PRG_END) begin
                            state <= S_CHR;
                        end else if (state == S_CHR && idx == CHR_END) begin
                            state <= S_FIN;
                        end
                    end else if (timeout_hit) begin
                        state    <= S_ERR;
                        err_code <= 2'd3;
                    end
                end
                S_FIN: begin
                    state <= S_DONE;
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_HDR;
                        idx      <= '0;
                        err_code <= 2'd0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

    localparam int IMG_BYTES = 'h6010;
`ifdef LOADER_TIMEOUT_EN
    localparam int LONG_GAP = 40;
`else
    localparam int LONG_GAP = 100;
`endif

    logic        cpu_clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        prog;
    logic [15:0] prog_ab;
    logic [7:0]  prog_di;
    logic        prog_we;
    logic        cpu_rst_n;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    rom_loader #(
        .HDR_BYTES  (16),
        .PRG_BYTES  ('h4000),
        .CHR_BYTES  ('h2000),
        .TIMEOUT_CYC(64)
    ) dut (
        .cpu_clk  (cpu_clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .prog     (prog),
        .prog_ab  (prog_ab),
        .prog_di  (prog_di),
        .prog_we  (prog_we),
        .cpu_rst_n(cpu_rst_n),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int cyc = 0;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    typedef struct {
        int         pos;
        logic [7:0] val;
        bit         exp_err;
        logic [1:0] exp_code;
    } hdr_vec_t;

    wr_t        exp_q[$];
    logic [7:0] img [0:IMG_BYTES-1];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         wr_count = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and score any write strobe seen there.
    task automatic tick();
        wr_t e;
        @(negedge cpu_clk);
        if (prog_we === 1'b1) begin
            wr_count++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_we: prog_ab=%0h prog_di=%0h, no write expected", prog_ab, prog_di);
            end else begin
                e = exp_q.pop_front();
                if (prog_ab !== e.addr || prog_di !== e.data || cyc != e.cyc + 1) begin
                    n_fail++;
                    $display("FAIL write: got ab=%0h di=%0h cyc=%0d expected ab=%0h di=%0h cyc=%0d",
                             prog_ab, prog_di, cyc, e.addr, e.data, e.cyc + 1);
                end
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int first, input int last_excl, input bit gaps);
        int w;
        for (int i = first; i < last_excl; i++) begin
            if (gaps) begin
                if ($urandom_range(0, 7) == 0) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) tick();
                end
                if (i % 4096 == 100) begin
                    in_valid = 1'b0;
                    repeat (LONG_GAP) tick();
                end
            end
            in_valid = 1'b1;
            in_data  = img[i];
            w = 0;
            while (in_ready !== 1'b1 && w < 50) begin
                tick();
                w++;
            end
            if (in_ready !== 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL stream_stall: byte %0h not accepted in 50 cycles", i);
                in_valid = 1'b0;
                return;
            end
            exp_q.push_back('{addr: 16'(i), data: img[i], cyc: cyc});
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  0);
        chk({tag, "_prog"},      32'(prog),      0);
        chk({tag, "_prog_ab"},   32'(prog_ab),   0);
        chk({tag, "_prog_di"},   32'(prog_di),   0);
        chk({tag, "_prog_we"},   32'(prog_we),   0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 0);
        chk({tag, "_done"},      32'(done),      0);
        chk({tag, "_err"},       32'(err),       0);
        chk({tag, "_err_code"},  32'(err_code),  0);
    endtask

    task automatic check_started(input string tag);
        chk({tag, "_st_prog"},      32'(prog),      1);
        chk({tag, "_st_in_ready"},  32'(in_ready),  1);
        chk({tag, "_st_done"},      32'(done),      0);
        chk({tag, "_st_err"},       32'(err),       0);
        chk({tag, "_st_err_code"},  32'(err_code),  0);
        chk({tag, "_st_cpu_rst_n"}, 32'(cpu_rst_n), 0);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"},      32'(done),      1);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 1);
        chk({tag, "_prog"},      32'(prog),      0);
        chk({tag, "_in_ready"},  32'(in_ready),  0);
        chk({tag, "_err"},       32'(err),       0);
        chk({tag, "_err_code"},  32'(err_code),  0);
        chk({tag, "_q_empty"},   32'(exp_q.size()), 0);
    endtask

    hdr_vec_t vecs[13];

    initial begin
        vecs[0]  = '{pos: 0,  val: 8'h4D, exp_err: 1'b1, exp_code: 2'd0};
        vecs[1]  = '{pos: 1,  val: 8'h44, exp_err: 1'b1, exp_code: 2'd0};
        vecs[2]  = '{pos: 2,  val: 8'h52, exp_err: 1'b1, exp_code: 2'd0};
        vecs[3]  = '{pos: 3,  val: 8'h1B, exp_err: 1'b1, exp_code: 2'd0};
        vecs[4]  = '{pos: 4,  val: 8'h02, exp_err: 1'b1, exp_code: 2'd1};
        vecs[5]  = '{pos: 4,  val: 8'h00, exp_err: 1'b1, exp_code: 2'd1};
        vecs[6]  = '{pos: 5,  val: 8'h02, exp_err: 1'b1, exp_code: 2'd1};
        vecs[7]  = '{pos: 6,  val: 8'h10, exp_err: 1'b1, exp_code: 2'd2};
        vecs[8]  = '{pos: 7,  val: 8'h80, exp_err: 1'b1, exp_code: 2'd2};
        vecs[9]  = '{pos: 6,  val: 8'h0F, exp_err: 1'b0, exp_code: 2'd0};
        vecs[10] = '{pos: 7,  val: 8'h0F, exp_err: 1'b0, exp_code: 2'd0};
        vecs[11] = '{pos: 8,  val: 8'hFF, exp_err: 1'b0, exp_code: 2'd0};
        vecs[12] = '{pos: 15, val: 8'h00, exp_err: 1'b0, exp_code: 2'd0};

        for (int i = 0; i < IMG_BYTES; i++) img[i] = 8'($urandom);
        img[0] = 8'h4E; img[1] = 8'h45; img[2] = 8'h53; img[3] = 8'h1A;
        img[4] = 8'h01; img[5] = 8'h01; img[6] = 8'h00; img[7] = 8'h00;

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) tick();
        check_reset_outs("reset");
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (2) tick();
        chk("idle_no_start_prog", 32'(prog), 0);
        chk("idle_no_start_ready", 32'(in_ready), 0);
        in_valid = 1'b0;

        // Partial load, ignored start mid-load, then reset at byte 'h2000.
        pulse_start();
        check_started("t6");
        stream(0, 'h100, 1'b0);
        pulse_start();
        stream('h100, 'h2000, 1'b0);
        rst = 1'b0;
        tick();
        check_reset_outs("midrst");
        rst = 1'b1;
        tick();

        // Full back-to-back image.
        wr_count = 0;
        pulse_start();
        check_started("t1");
        stream(0, IMG_BYTES, 1'b0);
        chk("fin_prog", 32'(prog), 1);
        chk("fin_done", 32'(done), 0);
        chk("fin_cpu_rst_n", 32'(cpu_rst_n), 0);
        tick();
        check_done("t1");
        chk("t1_write_count", 32'(wr_count), 32'(IMG_BYTES));

        // Header corruption table; each row starts from DONE, ERR or IDLE.
        for (int v = 0; v < 13; v++) begin
            logic [7:0] keep;
            keep = img[vecs[v].pos];
            img[vecs[v].pos] = vecs[v].val;
            pulse_start();
            check_started($sformatf("hdr%0d", v));
            stream(0, vecs[v].exp_err ? vecs[v].pos + 1 : 16, 1'b0);
            chk($sformatf("hdr%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
            chk($sformatf("hdr%0d_in_ready", v), 32'(in_ready), 32'(!vecs[v].exp_err));
            chk($sformatf("hdr%0d_cpu_rst_n", v), 32'(cpu_rst_n), 0);
            chk($sformatf("hdr%0d_done", v), 32'(done), 0);
            if (vecs[v].exp_err) begin
                chk($sformatf("hdr%0d_err_code", v), 32'(err_code), 32'(vecs[v].exp_code));
                chk($sformatf("hdr%0d_prog", v), 32'(prog), 0);
                in_valid = 1'b1;
                repeat (3) tick();
                in_valid = 1'b0;
                chk($sformatf("hdr%0d_err_hold", v), 32'(err), 1);
                chk($sformatf("hdr%0d_ready_hold", v), 32'(in_ready), 0);
            end else begin
                chk($sformatf("hdr%0d_prog", v), 32'(prog), 1);
                rst = 1'b0;
                tick();
                rst = 1'b1;
                tick();
            end
            img[vecs[v].pos] = keep;
        end

        // Mapper error, then restart with a gappy stream of a valid image.
        img[6] = 8'h10;
        pulse_start();
        stream(0, 7, 1'b0);
        chk("t3_err", 32'(err), 1);
        chk("t3_err_code", 32'(err_code), 2);
        img[6] = 8'h00;
        wr_count = 0;
        pulse_start();
        check_started("t4");
        stream(0, IMG_BYTES, 1'b1);
        tick();
        check_done("t4");
        chk("t4_write_count", 32'(wr_count), 32'(IMG_BYTES));

`ifdef LOADER_TIMEOUT_EN
        pulse_start();
        stream(0, 'h101, 1'b0);
        repeat (63) tick();
        chk("to_not_yet_err", 32'(err), 0);
        chk("to_not_yet_ready", 32'(in_ready), 1);
        tick();
        chk("to_err", 32'(err), 1);
        chk("to_err_code", 32'(err_code), 3);
        chk("to_in_ready", 32'(in_ready), 0);
        chk("to_prog", 32'(prog), 0);
        chk("to_cpu_rst_n", 32'(cpu_rst_n), 0);
`endif

        chk("final_q_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
